// File: rtl/up_down_ctrl_pkg.sv
// Shared types and constants for the direction controller that sits in front
// of the up/down counter.
package up_down_ctrl_pkg;

    // Debounce FSM states: idle, qualifying a press, held down, qualifying a release
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } db_state_t;

    // Direction encoding as seen by the counter
    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    // Counter width the controller is normally paired with, and its top value
    localparam int DEFAULT_CNT_W = 4;
    localparam int CNT_MAX       = (1 << DEFAULT_CNT_W) - 1;

    // Largest count value for an arbitrary counter width
    function automatic int cnt_max_of(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce FSM for a raw, bouncing push-button.
// Produces a single-cycle registered accept pulse once per debounced press;
// a further press is only recognised after a fully debounced release.
module btn_debounce
    import up_down_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic accept
);

    localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic          sync_meta;
    logic          sync_out;
    db_state_t     state;
    db_state_t     state_nxt;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] db_cnt_nxt;
    logic [CW-1:0] db_cnt_inc;
    logic          accept_nxt;

    // The debounce count holds at its limit instead of wrapping
    assign db_cnt_inc = (db_cnt == CNT_LIMIT) ? db_cnt : db_cnt + CNT_ONE;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync_out  <= sync_meta;
        end
    end

    // State, debounce count and accept pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            db_cnt <= '0;
            accept <= 1'b0;
        end else begin
            state  <= state_nxt;
            db_cnt <= db_cnt_nxt;
            accept <= accept_nxt;
        end
    end

    // Next state: any sample disagreeing with the level being qualified restarts it
    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        unique case (state)
            IDLE: begin
                if (sync_out) begin
                    state_nxt  = PRESS_CHK;
                    db_cnt_nxt = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (sync_out) begin
                    db_cnt_nxt = db_cnt_inc;
                    if (db_cnt_inc == CNT_LIMIT) begin
                        state_nxt = HELD;
                    end
                end else begin
                    state_nxt  = IDLE;
                    db_cnt_nxt = '0;
                end
            end
            HELD: begin
                if (!sync_out) begin
                    state_nxt  = REL_CHK;
                    db_cnt_nxt = CNT_ONE;
                end
            end
            REL_CHK: begin
                if (!sync_out) begin
                    db_cnt_nxt = db_cnt_inc;
                    if (db_cnt_inc == CNT_LIMIT) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt  = HELD;
                    db_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt  = IDLE;
                db_cnt_nxt = '0;
            end
        endcase
    end

    // Accept fires only on the step from press qualification into HELD
    always_comb begin
        accept_nxt = (state == PRESS_CHK) && (state_nxt == HELD);
    end

endmodule

// File: rtl/up_down_ctrl.sv
// Direction controller for the 4-bit up/down counter. A debounced press of
// dir_btn toggles up_down and pulses dir_chg for one cycle.
// Build option UP_DOWN_CTRL_AUTO_REVERSE_EN: also watch the counter's count
// and turn around one step before each end of the range, so the counter
// ping-pongs between 0 and its maximum; a reversal overrides a coincident
// button toggle. Without the option, count is ignored.
module up_down_ctrl
    import up_down_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dir_btn,
    input  logic [CNT_W-1:0] count,
    output logic             up_down,
    output logic             dir_chg
);

    logic btn_accept;
    logic up_down_nxt;
    logic dir_chg_nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(dir_btn),
        .accept (btn_accept)
    );

`ifdef UP_DOWN_CTRL_AUTO_REVERSE_EN
    localparam logic [CNT_W-1:0] TURN_DOWN_AT = CNT_W'(cnt_max_of(CNT_W) - 1);
    localparam logic [CNT_W-1:0] TURN_UP_AT   = CNT_W'(1);

    logic rev_down;
    logic rev_up;

    assign rev_down = (up_down == UP)   && (count == TURN_DOWN_AT);
    assign rev_up   = (up_down == DOWN) && (count == TURN_UP_AT);

    // End-of-range reversal takes priority over the button toggle
    always_comb begin
        up_down_nxt = up_down;
        dir_chg_nxt = 1'b0;
        if (rev_down) begin
            up_down_nxt = DOWN;
            dir_chg_nxt = 1'b1;
        end else if (rev_up) begin
            up_down_nxt = UP;
            dir_chg_nxt = 1'b1;
        end else if (btn_accept) begin
            up_down_nxt = ~up_down;
            dir_chg_nxt = 1'b1;
        end
    end
`else
    logic unused_count;
    assign unused_count = ^count;

    // Direction flips only on a debounced button press
    always_comb begin
        up_down_nxt = up_down;
        dir_chg_nxt = 1'b0;
        if (btn_accept) begin
            up_down_nxt = ~up_down;
            dir_chg_nxt = 1'b1;
        end
    end
`endif

    // Registered outputs keep the direction glitch-free to the counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_down <= UP;
            dir_chg <= 1'b0;
        end else begin
            up_down <= up_down_nxt;
            dir_chg <= dir_chg_nxt;
        end
    end

endmodule

// File: tb/tb_up_down_ctrl.sv
// Testbench for up_down_ctrl with DEBOUNCE_CYCLES=4 and a behavioural
// 4-bit up/down counter downstream, driven from up_down.
`timescale 1ns/1ps
module tb_up_down_ctrl;

    localparam int DB = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          dir_btn;
    logic [CW-1:0] count;
    logic          up_down;
    logic          dir_chg;

    int n_compared   = 0;
    int n_mismatched = 0;
    int pulse_cnt    = 0;

    typedef struct {
        logic       rst_n;
        logic       btn;
        logic       exp_ud;
        logic       exp_dc;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs[26];

    // Free-running clock
    always #5 clk = ~clk;

    up_down_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .dir_btn(dir_btn),
        .count  (count),
        .up_down(up_down),
        .dir_chg(dir_chg)
    );

    // Downstream counter, wrapping in both directions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (up_down) begin
            count <= count + 4'd1;
        end else begin
            count <= count - 4'd1;
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive inputs, advance one clock edge, sample just after it
    task automatic apply_stimulus(input logic rst_val, input logic btn_val);
        reset   = rst_val;
        dir_btn = btn_val;
        @(posedge clk);
        #1;
        if (dir_chg === 1'b1) pulse_cnt++;
    endtask

    task automatic drive_btn(input logic lvl, input int cycles);
        for (int i = 0; i < cycles; i++) apply_stimulus(1'b1, lvl);
    endtask

`ifdef UP_DOWN_CTRL_AUTO_REVERSE_EN
    logic       m_ud;
    logic [3:0] m_cnt;
    logic       m_dc;

    // Reference ping-pong behaviour: one step of counter and direction
    task automatic model_step_and_check(input logic btn_val, input string tag);
        logic nxt_ud;
        nxt_ud = m_ud;
        if (m_ud && m_cnt == 4'hE) nxt_ud = 1'b0;
        else if (!m_ud && m_cnt == 4'h1) nxt_ud = 1'b1;
        m_dc  = (nxt_ud != m_ud);
        m_cnt = m_ud ? m_cnt + 4'd1 : m_cnt - 4'd1;
        m_ud  = nxt_ud;
        apply_stimulus(1'b1, btn_val);
        check_output({tag, "_count"}, 8'(count), 8'(m_cnt));
        check_output({tag, "_up_down"}, 8'(up_down), 8'(m_ud));
        check_output({tag, "_dir_chg"}, 8'(dir_chg), 8'(m_dc));
    endtask
`else
    logic [3:0] prev_cnt;
    logic       wrapped;
`endif

    initial begin
        reset   = 1'b1;
        dir_btn = 1'b0;
        #2;

        // Reset with a toggling button, then a clean 10-cycle press and release
        for (int i = 0; i < 3; i++) vecs[i] = '{1'b0, ((i % 2) == 0), 1'b1, 1'b0, 4'h0};
        for (int i = 3; i < 6; i++) vecs[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'(i - 2)};
        for (int k = 0; k < 20; k++) begin
            if (k < 6)       vecs[6 + k] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'(4 + k)};
            else if (k == 6) vecs[6 + k] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'hA};
            else             vecs[6 + k] = '{1'b1, (k < 10), 1'b0, 1'b0, 4'(16 - k)};
        end

        for (int i = 0; i < 26; i++) begin
            apply_stimulus(vecs[i].rst_n, vecs[i].btn);
            check_output($sformatf("vec%0d_up_down", i), 8'(up_down), 8'(vecs[i].exp_ud));
            check_output($sformatf("vec%0d_dir_chg", i), 8'(dir_chg), 8'(vecs[i].exp_dc));
            check_output($sformatf("vec%0d_count", i), 8'(count), 8'(vecs[i].exp_cnt));
        end

        // Bounce never qualifies; a clean press afterwards toggles once
        pulse_cnt = 0;
        drive_btn(1'b1, 3);
        drive_btn(1'b0, 1);
        drive_btn(1'b1, 3);
        drive_btn(1'b0, 10);
        check_output("bounce_pulses", 8'(pulse_cnt), 8'd0);
        check_output("bounce_up_down", 8'(up_down), 8'd0);
        drive_btn(1'b1, 10);
        drive_btn(1'b0, 10);
        check_output("after_bounce_pulses", 8'(pulse_cnt), 8'd1);
        check_output("after_bounce_up_down", 8'(up_down), 8'd1);

        // Long hold, short release and re-press, then a full release and press
        pulse_cnt = 0;
        drive_btn(1'b1, 40);
        check_output("hold_pulses", 8'(pulse_cnt), 8'd1);
        check_output("hold_up_down", 8'(up_down), 8'd0);
        drive_btn(1'b0, 2);
        drive_btn(1'b1, 10);
        check_output("repress_pulses", 8'(pulse_cnt), 8'd1);
        check_output("repress_up_down", 8'(up_down), 8'd0);
        drive_btn(1'b0, 10);
        drive_btn(1'b1, 10);
        drive_btn(1'b0, 10);
        check_output("second_press_pulses", 8'(pulse_cnt), 8'd2);
        check_output("second_press_up_down", 8'(up_down), 8'd1);

        // Reset at the third PRESS_CHK edge abandons the press
        pulse_cnt = 0;
        drive_btn(1'b1, 5);
        apply_stimulus(1'b0, 1'b1);
        check_output("midreset_up_down", 8'(up_down), 8'd1);
        check_output("midreset_dir_chg", 8'(dir_chg), 8'd0);
        drive_btn(1'b1, 2);
        drive_btn(1'b0, 10);
        check_output("midreset_pulses", 8'(pulse_cnt), 8'd0);
        check_output("midreset_final_up_down", 8'(up_down), 8'd1);

`ifdef UP_DOWN_CTRL_AUTO_REVERSE_EN
        // Ping-pong from 0, then a press timed to accept on the E-cycle
        apply_stimulus(1'b0, 1'b0);
        m_ud  = 1'b1;
        m_cnt = 4'h0;
        for (int i = 0; i < 40; i++) model_step_and_check(1'b0, $sformatf("pp%0d", i));
        for (int i = 0; i < 64; i++) begin
            if (m_ud && m_cnt == 4'h8) break;
            model_step_and_check(1'b0, $sformatf("seek%0d", i));
        end
        pulse_cnt = 0;
        for (int i = 0; i < 10; i++) model_step_and_check(1'b1, $sformatf("coinc%0d", i));
        for (int i = 0; i < 10; i++) model_step_and_check(1'b0, $sformatf("coincrel%0d", i));
        check_output("coinc_pulses", 8'(pulse_cnt), 8'd1);
`else
        // Without auto-reverse the counter wraps and count has no effect
        pulse_cnt = 0;
        wrapped   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            prev_cnt = count;
            apply_stimulus(1'b1, 1'b0);
            if (prev_cnt == 4'hF && count == 4'h0) wrapped = 1'b1;
        end
        check_output("wrap_seen", 8'(wrapped), 8'd1);
        check_output("wrap_pulses", 8'(pulse_cnt), 8'd0);
        check_output("wrap_up_down", 8'(up_down), 8'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/up_down_ctrl.md
# up_down_ctrl

Direction controller sitting directly upstream of the 4-bit up/down counter: it takes a raw, bouncing direction push-button, synchronises and debounces it, and drives the counter's `up_down` input, toggling direction once per accepted press. With the optional auto-reverse feature it also consumes the counter's `count` output and reverses direction at the ends of the range, turning the counter into a 0↔15 ping-pong sequencer.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronised-high (or low) samples required to accept a press (or release); legal range 2..65535.
- `CNT_W`, default 4: width of `count`, matching the counter.
- `clk`  in  1  rising-edge clock, shared with the counter.
- `reset`  in  1  asynchronous, active-low reset; the one clock and this reset are the only timing references.
- `dir_btn`  in  1  raw push-button, asynchronous to `clk`, active-high, may bounce.
- `count`  in  CNT_W  counter output; only used when auto-reverse is compiled in.
- `up_down`  out  1  direction to the counter: 1 = up, 0 = down. Registered.
- `dir_chg`  out  1  one-cycle pulse, high in the first cycle `up_down` shows a new value. Registered.

## Operation
- `dir_btn` passes through a 2-flop synchroniser, then a debounce FSM:
  - IDLE: synced input low. Synced high → PRESS_CHK, counter = 1.
  - PRESS_CHK: synced high → counter+1; on reaching `DEBOUNCE_CYCLES` → HELD and emit accept pulse. Synced low → IDLE, counter cleared.
  - HELD: synced low → REL_CHK, counter = 1.
  - REL_CHK: synced low → counter+1; on reaching `DEBOUNCE_CYCLES` → IDLE. Synced high → HELD, counter cleared.
- Each accept pulse toggles `up_down` and pulses `dir_chg`. A held button produces exactly one toggle. A new press requires a full debounced release first.
- Debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`. It saturates and never wraps.
- Reset values: `up_down`=1, `dir_chg`=0, sync flops=0, FSM=IDLE, debounce counter=0.
- Reset asserted mid-debounce abandons the press. No toggle occurs after release of reset unless a fresh full press is seen.

## Timing
- Latency: with `dir_btn` sampled high at edge N and held, `up_down` changes at edge N+`DEBOUNCE_CYCLES`+2, and `dir_chg` is high for the following cycle only.
- Any low synced sample during PRESS_CHK restarts the count. Glitches shorter than `DEBOUNCE_CYCLES` cycles never toggle.
- `up_down` changes only on a clock edge and is glitch-free to the counter.

## Configuration
- `UP_DOWN_CTRL_AUTO_REVERSE_EN` defined:
  - If `up_down`=1 and `count`==MAX−1 (4'hE), `up_down` is set to 0 at that edge.
  - If `up_down`=0 and `count`==1, `up_down` is set to 1 at that edge.
  - The counter therefore runs …E,F,E,D… and …2,1,0,1,2…, with no wrap.
  - Each reversal pulses `dir_chg`.
  - If a button accept coincides with an auto-reverse, the auto-reverse value wins, the button toggle is discarded, and `dir_chg` pulses once.
- Macro undefined: `count` is ignored (left unconnected internally). Direction changes only via the button, and the counter wraps normally.

## Structure
- Package `up_down_ctrl_pkg` holds:
  - the debounce FSM state enum (IDLE, PRESS_CHK, HELD, REL_CHK);
  - localparams `UP`=1'b1 and `DOWN`=1'b0;
  - `CNT_MAX` derived from `CNT_W`.
- One sub-module, `btn_debounce`, contains the synchroniser, FSM and debounce counter, and outputs the accept pulse. The top level holds the direction register, the `dir_chg` register and the auto-reverse logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, with the counter instantiated downstream.
- Reset: hold `reset`=0 for 3 cycles with `dir_btn` toggling → `up_down`=1 and `dir_chg`=0 throughout; counter `count`=0.
- Clean press: after reset, hold `dir_btn`=1 for 10 cycles → `up_down` goes 1→0 exactly 6 edges after the first high sample, `dir_chg` is high for 1 cycle, and the counter starts decrementing.
- Bounce: pulse `dir_btn` high 3 cycles, low 1, high 3, low → no toggle. Then a clean 10-cycle press → exactly one toggle.
- Hold then re-press: hold 40 cycles (one toggle), release 2 cycles, press 10 cycles → still one toggle total. Release 10 cycles, press 10 → second toggle, `up_down` back to 1.
- Reset mid-debounce: press, then assert `reset` at edge 3 of PRESS_CHK, release `reset`, keep the button high 2 more cycles then low → no toggle; `up_down`=1.
- Auto-reverse (macro defined): count up from 0 → `count` sequence 0..F,E,…,1,0,1; `dir_chg` pulses at edges where `count` goes E→F and 1→0. A button accept on the E-cycle is discarded.
